// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the memory-stage bus and the data-memory responder.
//   BUS_AW / BUS_DW / BUS_MW : address, data and byte-mask widths
//   dmem_state_t             : init / ready state of the data memory
// ---------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_MW = 4;

    typedef enum logic {
        DMEM_INIT  = 1'b0,
        DMEM_READY = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/bus_if.sv
// ---------------------------------------------------------------------------
// bus_if
// Load/store bus between the memory stage (master) and a memory responder
// (slave). Every request is accepted in the cycle it is presented; read data
// comes back one cycle after ren.
//   ren, raddr          : read request and byte address
//   wen, waddr, wdata   : write request, byte address, lane-aligned data
//   bytemask            : write byte-lane enables
//   rdata               : registered read data
// ---------------------------------------------------------------------------
interface bus_if;
    import bus_pkg::*;

    logic              ren;
    logic              wen;
    logic [BUS_AW-1:0] raddr;
    logic [BUS_AW-1:0] waddr;
    logic [BUS_DW-1:0] wdata;
    logic [BUS_MW-1:0] bytemask;
    logic [BUS_DW-1:0] rdata;

    modport master (
        output ren, wen, raddr, waddr, wdata, bytemask,
        input  rdata
    );

    modport slave (
        input  ren, wen, raddr, waddr, wdata, bytemask,
        output rdata
    );

endinterface

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit storage with one byte-masked write port and one synchronous
// read port. A read and write to the same word in one cycle returns the
// merged word (write-first).
//   clk, rst_n : clock, asynchronous active-low reset (read register only)
//   we, wmask  : write enable and byte-lane enables
//   widx, wdata: write word index and data
//   re         : read enable; rdata holds when low
//   rzero      : force the read result to zero (miss or not yet initialised)
//   ridx       : read word index
//   rdata      : registered read data
// ---------------------------------------------------------------------------
module dmem_array
    import bus_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [BUS_MW-1:0] wmask,
    input  logic [IW-1:0]     widx,
    input  logic [BUS_DW-1:0] wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [IW-1:0]     ridx,
    output logic [BUS_DW-1:0] rdata
);

    logic [BUS_DW-1:0] mem [DEPTH];
    logic [BUS_DW-1:0] rword;

    // Write-first bypass: new bytes in enabled lanes, stored bytes elsewhere.
    always_comb begin
        rword = mem[ridx];
        if (we && (widx == ridx)) begin
            for (int i = 0; i < BUS_MW; i++) begin
                if (wmask[i]) begin
                    rword[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BUS_MW; i++) begin
                if (wmask[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : rword;
        end
    end

endmodule

// File: rtl/bus_dmem.sv
// ---------------------------------------------------------------------------
// bus_dmem
// Data-memory responder on the slave side of bus_if. Decodes byte addresses
// into word indices, optionally zero-fills the array after reset, and keeps a
// sticky record of the first out-of-range (or during-init write) access.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bus_if slave (ren/wen/raddr/waddr/wdata/bytemask in, rdata out)
//   init_done  : high once the array is usable
//   err        : sticky access error
//   err_addr   : byte address of the first error since the last clear
//   err_clr    : clears err / err_addr (a simultaneous new error wins)
// ---------------------------------------------------------------------------
module bus_dmem
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          ZERO_INIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_if.slave              bus,
    output logic              init_done,
    output logic              err,
    output logic [BUS_AW-1:0] err_addr,
    input  logic              err_clr
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Word offset from the base. BASE_ADDR is word aligned, so subtracting in
    // word units equals the 32-bit byte subtraction with the low bits dropped.
    function automatic logic [29:0] word_off(input logic [BUS_AW-1:0] addr);
        return addr[31:2] - BASE_ADDR[31:2];
    endfunction

    function automatic logic is_hit(input logic [29:0] woff);
        return ({2'b00, woff} < 32'(DEPTH));
    endfunction

    logic [29:0]   roff, woff;
    logic          rhit, whit;
    logic [IW-1:0] ridx, widx;

    assign roff = word_off(bus.raddr);
    assign woff = word_off(bus.waddr);
    assign rhit = is_hit(roff);
    assign whit = is_hit(woff);
    assign ridx = roff[IW-1:0];
    assign widx = woff[IW-1:0];

    // Byte-offset bits are ignored by the decode.
    logic unused_low_bits;
    assign unused_low_bits = ^{bus.raddr[1:0], bus.waddr[1:0]};

    // ------------------------------------------------------------------
    // Init FSM
    // ------------------------------------------------------------------
    dmem_state_t   state;
    logic [IW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= (ZERO_INIT != 0) ? DMEM_INIT : DMEM_READY;
            cnt       <= '0;
            init_done <= (ZERO_INIT == 0);
        end else begin
            case (state)
                DMEM_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == IW'(DEPTH - 1)) begin
                        state     <= DMEM_READY;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= DMEM_READY;
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write-port mux: the init sweep owns the port until READY.
    // ------------------------------------------------------------------
    logic              arr_we;
    logic [BUS_MW-1:0] arr_wmask;
    logic [IW-1:0]     arr_widx;
    logic [BUS_DW-1:0] arr_wdata;
    logic              in_init;

    assign in_init = (state == DMEM_INIT);

    always_comb begin
        arr_we    = bus.wen && whit;
        arr_wmask = bus.bytemask;
        arr_widx  = widx;
        arr_wdata = bus.wdata;
        if (in_init) begin
            arr_we    = 1'b1;
            arr_wmask = '1;
            arr_widx  = cnt;
            arr_wdata = '0;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .wmask (arr_wmask),
        .widx  (arr_widx),
        .wdata (arr_wdata),
        .re    (bus.ren),
        .rzero (!rhit || in_init),
        .ridx  (ridx),
        .rdata (bus.rdata)
    );

    // ------------------------------------------------------------------
    // Sticky error capture. A read miss takes priority over a write error
    // in the same cycle; a new error overrides a simultaneous clear.
    // ------------------------------------------------------------------
    logic              rd_err, wr_err, new_err;
    logic [BUS_AW-1:0] new_addr;

    assign rd_err   = bus.ren && !rhit;
    assign wr_err   = bus.wen && (in_init || !whit);
    assign new_err  = rd_err || wr_err;
    assign new_addr = rd_err ? bus.raddr : bus.waddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (new_err && (!err || err_clr)) begin
            err      <= 1'b1;
            err_addr <= new_addr;
        end else if (err_clr) begin
            err      <= 1'b0;
            err_addr <= '0;
        end
    end

endmodule

// File: tb/tb_bus_dmem.sv
module tb_bus_dmem;
    import bus_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done;
    logic        err;
    logic [31:0] err_addr;
    logic        err_clr = 1'b0;

    bus_if bus ();

    bus_dmem #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .ZERO_INIT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done),
        .err       (err),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the memory as plain words, expected outputs, and the
    // number of clock edges seen since reset release.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rdata;
    logic        m_err;
    logic [31:0] m_eaddr;
    int          m_edges;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_rdata = 0; m_err = 0; m_eaddr = 0; m_edges = 0;
    endtask

    function automatic bit addr_hit(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off / 4) < DEPTH;
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off / 4);
    endfunction

    task automatic model_edge();
        bit ready, rh, wh, rerr, werr;
        ready = (m_edges >= DEPTH);
        rh = addr_hit(bus.raddr);
        wh = addr_hit(bus.waddr);
        if (ready && bus.wen && wh) begin
            for (int b = 0; b < 4; b++)
                if (bus.bytemask[b])
                    m_mem[addr_idx(bus.waddr)][8*b +: 8] = bus.wdata[8*b +: 8];
        end
        if (bus.ren) m_rdata = (rh && ready) ? m_mem[addr_idx(bus.raddr)] : 32'h0;
        rerr = bus.ren && !rh;
        werr = bus.wen && (!ready || !wh);
        if ((rerr || werr) && (!m_err || err_clr)) begin
            m_err = 1; m_eaddr = rerr ? bus.raddr : bus.waddr;
        end else if (err_clr) begin
            m_err = 0; m_eaddr = 0;
        end
        if (!ready) m_edges++;
    endtask

    task automatic check_all();
        chk("rdata", bus.rdata, m_rdata);
        chk("err", {31'b0, err}, {31'b0, m_err});
        chk("err_addr", err_addr, m_eaddr);
        chk("init_done", {31'b0, init_done}, {31'b0, (m_edges >= DEPTH)});
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic ren, input logic [31:0] ra, input logic wen,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] m, input logic clr);
        bus.ren = ren; bus.raddr = ra; bus.wen = wen; bus.waddr = wa;
        bus.wdata = wd; bus.bytemask = m; err_clr = clr;
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int w;
        if ($urandom_range(0, 19) == 0) return $urandom;
        w = int'($urandom_range(0, DEPTH + 3)) - 2;
        return BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
    endfunction

    // Reset asserted mid-cycle, checked immediately, then held over one edge.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_init_done", {31'b0, init_done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Init sweep, with a write attempted during it.
        n = 0;
        while (!init_done && n < 100) begin
            if (n == 3) drive(0, 0, 1, BASE, 32'h1234_5678, 4'hF, 0);
            else idle();
            step();
            n++;
        end
        chk("init_len", n, DEPTH);
        chk("init_werr", {31'b0, err}, 32'h1);
        chk("init_eaddr", err_addr, BASE);

        drive(1, BASE + 32'h3C, 0, 0, 0, 0, 0); step();
        chk("rd_last_word", bus.rdata, 32'h0);
        drive(1, BASE, 0, 0, 0, 0, 1); step();
        chk("rd_dropped", bus.rdata, 32'h0);
        chk("clr_err", {31'b0, err}, 32'h0);

        // Byte-lane merge.
        drive(0, 0, 1, BASE + 8, 32'hDEAD_BEEF, 4'b1111, 0); step();
        drive(0, 0, 1, BASE + 8, 32'h0000_00AA, 4'b0001, 0); step();
        drive(1, BASE + 8, 0, 0, 0, 0, 0); step();
        chk("lane_merge", bus.rdata, 32'hDEAD_BEAA);

        // Same-cycle read/write of one word returns the merged word.
        drive(0, 0, 1, BASE + 4, 32'h1122_3344, 4'hF, 0); step();
        drive(1, BASE + 4, 1, BASE + 4, 32'hFFFF_FFFF, 4'b1100, 0); step();
        chk("write_first", bus.rdata, 32'hFFFF_3344);
        idle(); step();
        chk("hold", bus.rdata, 32'hFFFF_3344);

        // Misses and sticky capture.
        drive(1, BASE + DEPTH * 4, 0, 0, 0, 0, 0); step();
        chk("miss_rdata", bus.rdata, 32'h0);
        chk("miss_err", {31'b0, err}, 32'h1);
        chk("miss_eaddr", err_addr, BASE + DEPTH * 4);
        drive(1, BASE - 4, 0, 0, 0, 0, 0); step();
        chk("sticky_eaddr", err_addr, BASE + DEPTH * 4);
        drive(0, 0, 0, 0, 0, 0, 1); step();
        chk("clr_eaddr", err_addr, 32'h0);
        drive(1, BASE + 32'h100, 0, 0, 0, 0, 1); step();
        chk("clr_vs_new", err_addr, BASE + 32'h100);
        drive(0, 0, 0, 0, 0, 0, 1); step();
        drive(1, BASE + 32'h80, 1, BASE + 32'h200, 32'h1, 4'hF, 0); step();
        chk("rd_priority", err_addr, BASE + 32'h80);
        drive(0, 0, 1, BASE + 8, 32'h5555_5555, 4'h0, 1); step();
        chk("mask0_noerr", {31'b0, err}, 32'h0);
        drive(1, BASE + 8, 0, 0, 0, 0, 0); step();
        chk("mask0_nochange", bus.rdata, 32'hDEAD_BEAA);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 1), rand_addr(), $urandom_range(0, 1), rand_addr(),
                  $urandom, 4'($urandom), ($urandom_range(0, 11) == 0));
            step();
        end

        // Reset mid-access, then mid-init at cnt = 7.
        drive(0, 0, 1, BASE + 12, 32'hCAFE_F00D, 4'hF, 0); step();
        drive(1, BASE + 12, 0, 0, 0, 0, 0); step();
        chk("pre_rst_rd", bus.rdata, 32'hCAFE_F00D);
        idle();
        async_reset();
        for (int k = 0; k < 7; k++) step();
        async_reset();
        n = 0;
        while (!init_done && n < 100) begin
            step();
            n++;
        end
        chk("reinit_len", n, DEPTH);
        drive(1, BASE + 12, 0, 0, 0, 0, 0); step();
        chk("reinit_cleared", bus.rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
